// File: rtl/roll_sequencer.sv
// ---------------------------------------------------------------------------
// roll_sequencer
//
// Electronic dice sequencer. A button press selects a die (d4..d100), the
// die size is shown while the button is held, and on release a spin
// animation of SPIN_STEPS pseudo-random values plays. The gaps between
// values stretch as the spin progresses (1 + n/4 prescaler ticks). The
// last value stays on the display as the result.
//
// Random values come from a free-running 16-bit Fibonacci LFSR. The 7-bit
// sample is reduced modulo the die size by repeated subtraction. It is then
// converted to BCD by repeated subtraction of ten. Both loops take one step
// per clock, which is fast compared with the 32 Hz tick.
//
// Ports
//   clk      in   system clock, all logic on its rising edge
//   rst      in   synchronous active-high reset
//   tick     in   one-cycle 32 Hz prescaler pulse
//   btn_sel  in   debounced buttons, bit0..6 = d4, d6, d8, d10, d12, d20, d100
//   digit10  out  BCD tens digit
//   digit1   out  BCD units digit
//   blank10  out  tens digit is a suppressed leading zero
//   rolling  out  spin animation in progress
//   done     out  one-cycle pulse when the final result appears
// ---------------------------------------------------------------------------
module roll_sequencer #(
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          SPIN_STEPS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [6:0] btn_sel,
   output logic [3:0] digit10,
   output logic [3:0] digit1,
   output logic       blank10,
   output logic       rolling,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, HELD, REDUCE, BCD, WAIT, SHOW} state_t;

   localparam logic [5:0] LAST_STEP = 6'(SPIN_STEPS - 1);

   state_t      state;
   logic [15:0] lfsr;
   logic        btn_q;
   logic        armed;
   logic [6:0]  sides;
   logic [6:0]  r;
   logic [6:0]  work;
   logic [3:0]  tens;
   logic [5:0]  n;
   logic [4:0]  wcnt;

   logic        btn_any;
   logic        press;
   logic        accept;
   logic        lfsr_fb;
   logic [4:0]  wait_target;
   logic [4:0]  wcnt_next;
   logic [6:0]  sel_sides;
   logic [3:0]  sel_d10;
   logic [3:0]  sel_d1;
   logic        sel_blank;

   // A press needs a rising edge of the OR of all buttons. 'armed' stays
   // low after reset until the buttons have been seen released once. This
   // stops a button held through reset from counting as a fresh press.
   assign btn_any = |btn_sel;
   assign press   = btn_any & ~btn_q & armed;
   assign accept  = press & ((state == IDLE) | (state == HELD) | (state == SHOW));

   // Taps 16, 14, 13, 11 of a right-shifting Fibonacci register.
   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   // The spin slows down: the gap after value n lasts 1 + n/4 ticks.
   assign wait_target = {1'b0, n[5:2]} + 5'd1;
   assign wcnt_next   = wcnt + 5'd1;

   // The lowest pressed button wins. The die size is also precomputed in
   // display form so it can be shown while the button is held. The d100 die
   // reads as "00", and its tens digit is not blanked.
   always_comb begin
      sel_sides = 7'd100;
      sel_d10   = 4'd0;
      sel_d1    = 4'd0;
      sel_blank = 1'b0;
      if (btn_sel[0]) begin
         sel_sides = 7'd4;  sel_d10 = 4'd0; sel_d1 = 4'd4; sel_blank = 1'b1;
      end else if (btn_sel[1]) begin
         sel_sides = 7'd6;  sel_d10 = 4'd0; sel_d1 = 4'd6; sel_blank = 1'b1;
      end else if (btn_sel[2]) begin
         sel_sides = 7'd8;  sel_d10 = 4'd0; sel_d1 = 4'd8; sel_blank = 1'b1;
      end else if (btn_sel[3]) begin
         sel_sides = 7'd10; sel_d10 = 4'd1; sel_d1 = 4'd0; sel_blank = 1'b0;
      end else if (btn_sel[4]) begin
         sel_sides = 7'd12; sel_d10 = 4'd1; sel_d1 = 4'd2; sel_blank = 1'b0;
      end else if (btn_sel[5]) begin
         sel_sides = 7'd20; sel_d10 = 4'd2; sel_d1 = 4'd0; sel_blank = 1'b0;
      end
   end

   // Main sequencer. The display outputs are registered and change only
   // when a press is accepted or when a BCD conversion finishes. So the
   // display never shows a value that is only partly converted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         lfsr    <= LFSR_SEED;
         btn_q   <= 1'b0;
         armed   <= 1'b0;
         sides   <= 7'd0;
         r       <= 7'd0;
         work    <= 7'd0;
         tens    <= 4'd0;
         n       <= 6'd0;
         wcnt    <= 5'd0;
         digit10 <= 4'd0;
         digit1  <= 4'd0;
         blank10 <= 1'b1;
         rolling <= 1'b0;
         done    <= 1'b0;
      end else begin
         lfsr  <= {lfsr_fb, lfsr[15:1]};
         btn_q <= btn_any;
         if (!btn_any) begin
            armed <= 1'b1;
         end
         done <= 1'b0;

         if (accept) begin
            state   <= HELD;
            sides   <= sel_sides;
            digit10 <= sel_d10;
            digit1  <= sel_d1;
            blank10 <= sel_blank;
            rolling <= 1'b0;
         end else begin
            case (state)
               HELD: begin
                  if (!btn_any) begin
                     r       <= lfsr[6:0];
                     n       <= 6'd0;
                     rolling <= 1'b1;
                     state   <= REDUCE;
                  end
               end
               REDUCE: begin
                  if (r >= sides) begin
                     r <= r - sides;
                  end else begin
                     work  <= r + 7'd1;
                     tens  <= 4'd0;
                     state <= BCD;
                  end
               end
               BCD: begin
                  if (work >= 7'd10) begin
                     work <= work - 7'd10;
                     tens <= tens + 4'd1;
                  end else begin
                     // Ten tens is the value 100, which shows as "00" with
                     // the tens digit lit.
                     if (tens == 4'd10) begin
                        digit10 <= 4'd0;
                        digit1  <= 4'd0;
                        blank10 <= 1'b0;
                     end else begin
                        digit10 <= tens;
                        digit1  <= work[3:0];
                        blank10 <= (tens == 4'd0);
                     end
                     if (n == LAST_STEP) begin
                        rolling <= 1'b0;
                        done    <= 1'b1;
                        state   <= SHOW;
                     end else begin
                        wcnt  <= 5'd0;
                        state <= WAIT;
                     end
                  end
               end
               WAIT: begin
                  if (tick) begin
                     if (wcnt_next == wait_target) begin
                        n     <= n + 6'd1;
                        r     <= lfsr[6:0];
                        state <= REDUCE;
                     end else begin
                        wcnt <= wcnt_next;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_roll_sequencer.sv
// ---------------------------------------------------------------------------
// tb_roll_sequencer
//
// Directed-plus-random bench for roll_sequencer. A reference model predicts
// every displayed value from the die rules: sample = low 7 bits of the
// polynomial LFSR, value = sample mod sides + 1. The bench knows which clock
// edge samples the LFSR because it drives the release and the tick pulses
// itself. Ticks are spaced far enough apart that every tick lands in the
// waiting phase. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_roll_sequencer;

   localparam logic [15:0] SEED  = 16'hACE1;
   localparam int          STEPS = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick;
   logic [6:0] btn_sel;
   logic [3:0] digit10;
   logic [3:0] digit1;
   logic       blank10;
   logic       rolling;
   logic       done;

   int          errors    = 0;
   int          checks    = 0;
   int          doneTotal = 0;
   logic [15:0] modelLfsr;

   roll_sequencer #(
      .LFSR_SEED (SEED),
      .SPIN_STEPS(STEPS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .btn_sel(btn_sel),
      .digit10(digit10),
      .digit1 (digit1),
      .blank10(blank10),
      .rolling(rolling),
      .done   (done)
   );

   always #5 clk = ~clk;

   // One shift of a Fibonacci register for x^16+x^14+x^13+x^11+1. Exponent
   // e feeds from bit (16 - e) when the register shifts right.
   function automatic logic [15:0] lfsrNext(input logic [15:0] s);
      int   taps [4];
      logic fb;
      taps = '{16, 14, 13, 11};
      fb   = 1'b0;
      for (int i = 0; i < 4; i++) fb = fb ^ s[16 - taps[i]];
      return {fb, s[15:1]};
   endfunction

   // Model register that tracks the DUT's free-running LFSR.
   always @(posedge clk) begin
      if (rst) modelLfsr <= SEED;
      else     modelLfsr <= lfsrNext(modelLfsr);
   end

   // Count every cycle in which done is high.
   always @(negedge clk) begin
      if (done === 1'b1) doneTotal++;
   end

   function automatic int sidesOf(input logic [6:0] p);
      int tbl [7];
      tbl = '{4, 6, 8, 10, 12, 20, 100};
      for (int i = 0; i < 7; i++) if (p[i]) return tbl[i];
      return 0;
   endfunction

   // Expected {digit10, digit1, blank10} for a value 1..100.
   function automatic logic [8:0] dispOf(input int v);
      if (v == 100) return 9'b0000_0000_0;
      return {4'(v / 10), 4'(v % 10), (v < 10) ? 1'b1 : 1'b0};
   endfunction

   task automatic applyStimulus(input logic [6:0] b, input logic t);
      @(negedge clk);
      btn_sel = b;
      tick    = t;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete roll. pressInWait presses d6 while the DUT waits for
   // ticks. holdThroughShow keeps the die button down across the result.
   task automatic doRoll(input logic [6:0] pat, input int hold,
                         input bit pressInWait, input bit holdThroughShow);
      int         s;
      int         gap;
      int         v;
      int         t;
      int         d0;
      logic [6:0] r;
      logic [6:0] gb;
      s   = sidesOf(pat);
      gap = 127 / s + 16;
      d0  = doneTotal;

      applyStimulus(pat, 1'b0);
      for (int i = 0; i < hold; i++)
         applyStimulus((i == hold / 2) ? 7'h7F : pat, (i == 0) ? 1'b1 : 1'b0);
      checkOutput("held_disp", 16'({digit10, digit1, blank10}), 16'(dispOf(s)));
      checkOutput("held_rolling", 16'(rolling), 16'd0);

      applyStimulus(7'd0, 1'b0);
      r = modelLfsr[6:0];
      applyStimulus(7'd0, 1'b1);
      checkOutput("roll_start", 16'(rolling), 16'd1);
      applyStimulus(7'd0, 1'b0);
      repeat (gap) applyStimulus(7'd0, 1'b0);
      v = int'(r) % s + 1;
      checkOutput("value0", 16'({digit10, digit1, blank10, rolling}), 16'({dispOf(v), 1'b1}));

      for (int k = 0; k < STEPS - 1; k++) begin
         t = 1 + k / 4;
         for (int j = 0; j < t; j++) begin
            if (k == STEPS - 2 && j == t - 1)
               checkOutput("done_early", 16'(doneTotal - d0), 16'd0);
            applyStimulus(7'd0, 1'b1);
            if (j == t - 1) r = modelLfsr[6:0];
            applyStimulus(7'd0, 1'b0);
            for (int i = 0; i < gap; i++) begin
               gb = 7'd0;
               if (pressInWait && k == 3 && j == t - 1 && i >= gap - 5) gb = 7'b0000010;
               if (holdThroughShow && k == STEPS - 2 && j == t - 1) gb = pat;
               applyStimulus(gb, 1'b0);
            end
         end
         v = int'(r) % s + 1;
         checkOutput("value", 16'({digit10, digit1, blank10, rolling}),
                     16'({dispOf(v), (k != STEPS - 2) ? 1'b1 : 1'b0}));
      end
      checkOutput("done_once", 16'(doneTotal - d0), 16'd1);

      if (holdThroughShow) begin
         repeat (20) applyStimulus(pat, 1'b0);
         checkOutput("show_hold", 16'({digit10, digit1, blank10, rolling}), 16'({dispOf(v), 1'b0}));
         checkOutput("show_no_done", 16'(doneTotal - d0), 16'd1);
      end
      applyStimulus(7'd0, 1'b0);
      applyStimulus(7'd0, 1'b0);
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [6:0] p;
      logic [6:0] r;
      int         d0;
      rst     = 1'b1;
      tick    = 1'b0;
      btn_sel = 7'd0;

      applyStimulus(7'd0, 1'b0);
      applyStimulus(7'd0, 1'b0);
      checkOutput("reset_vals", 16'({digit10, digit1, blank10, rolling, done}), 16'b000_0000_0000_100);

      // Button held across reset must not start anything.
      applyStimulus(7'b0000010, 1'b0);
      applyStimulus(7'b0000010, 1'b0);
      rst = 1'b0;
      repeat (5) applyStimulus(7'b0000010, 1'b0);
      checkOutput("held_thru_rst", 16'({digit10, digit1, blank10, rolling, done}), 16'b000_0000_0000_100);
      applyStimulus(7'd0, 1'b0);
      applyStimulus(7'd0, 1'b0);

      doRoll(7'b0000001, 10, 1'b1, 1'b1);
      doRoll(7'b0100100, 4, 1'b0, 1'b0);
      doRoll(7'b1110000, 6, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) doRoll(7'b1000000, int'($urandom_range(1, 8)), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         p = 7'($urandom_range(1, 127));
         doRoll(p, int'($urandom_range(1, 12)), 1'b0, ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0);
      end

      // Partial d10 roll, then reset while the DUT waits for ticks.
      d0 = doneTotal;
      applyStimulus(7'b0001000, 1'b0);
      repeat (3) applyStimulus(7'b0001000, 1'b0);
      applyStimulus(7'd0, 1'b0);
      r = modelLfsr[6:0];
      repeat (30) applyStimulus(7'd0, 1'b0);
      checkOutput("pre_rst_value", 16'({digit10, digit1, blank10, rolling}),
                  16'({dispOf(int'(r) % 10 + 1), 1'b1}));
      applyStimulus(7'd0, 1'b1);
      applyStimulus(7'd0, 1'b0);
      repeat (30) applyStimulus(7'd0, 1'b0);
      rst = 1'b1;
      applyStimulus(7'd0, 1'b0);
      checkOutput("mid_wait_rst", 16'({digit10, digit1, blank10, rolling, done}), 16'b000_0000_0000_100);
      rst = 1'b0;
      checkOutput("rst_no_done", 16'(doneTotal - d0), 16'd0);
      repeat (3) applyStimulus(7'd0, 1'b0);
      doRoll(7'b0001000, 3, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
